// File: rtl/dir_entry_if.sv
`default_nettype none
// ============================================================================
// Module   : dir_entry_if
// Brief    : Request and byte-stream bundle for the directory entry generator.
// Revision : 1.0 - initial release
// ============================================================================

interface dir_entry_if;
  logic                 start;
  logic [7:0]           fnamelen;
  logic [51:0][7:0]     fname;
  logic [15:0]          fcluster;
  logic [31:0]          fsize;
  logic                 wready;
  logic                 wvalid;
  logic [4:0]           waddr;
  logic [7:0]           wdata;
  logic                 busy;
  logic                 done;
  logic                 err;

  modport master (
    output start, fnamelen, fname, fcluster, fsize, wready,
    input  wvalid, waddr, wdata, busy, done, err
  );

  modport slave (
    input  start, fnamelen, fname, fcluster, fsize, wready,
    output wvalid, waddr, wdata, busy, done, err
  );
endinterface

`default_nettype wire

// File: rtl/dir_entry_gen.sv
`default_nettype none
// ============================================================================
// Module   : dir_entry_gen
// Brief    : Validates an 8.3 file name and streams the 32-byte FAT entry.
// Revision : 1.0 - initial release
// ============================================================================

module dir_entry_gen (
  input  wire logic  clk,
  input  wire logic  rst_n,
  dir_entry_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    FILL = 2'd2,
    EMIT = 2'd3
  } state_t;

  localparam int         C_NAME_MAX  = 12;
  localparam logic [7:0] C_SPACE     = 8'h20;
  localparam logic [7:0] C_DOT       = 8'h2E;
  localparam logic [4:0] C_LAST_ADDR = 5'h1F;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [7:0]  r_name [C_NAME_MAX];
  logic [3:0]  r_len;
  logic [3:0]  r_idx;
  logic [3:0]  r_dot_idx;
  logic        r_has_dot;
  logic        r_bad;
  logic [7:0]  r_base [8];
  logic [7:0]  r_ext  [3];
  logic [15:0] r_cluster;
  logic [31:0] r_size;
  logic        r_wvalid;
  logic [4:0]  r_waddr;
  logic        r_busy;
  logic        r_done;
  logic        r_err;

  logic        w_start_seen;
  logic        w_len_bad;
  logic        w_accept;
  logic        w_last;
  logic        w_xfer;
  logic [7:0]  w_char;
  logic [7:0]  w_upper;
  logic [7:0]  w_entry;
  logic        w_in_base;
  logic        w_is_sep;
  logic [3:0]  w_ext_pos;
  logic        w_char_bad;
  logic        w_fill_bad;

  function automatic logic f_illegal(input logic [7:0] c);
    return (c < 8'h21) || (c == 8'h22) || (c >= 8'h2A && c <= 8'h2C) || (c == 8'h2F)
        || (c >= 8'h3A && c <= 8'h3F) || (c >= 8'h5B && c <= 8'h5D)
        || (c == 8'h7C) || (c == 8'h7F);
  endfunction

  // A start coinciding with the done pulse is deliberately dropped
  assign w_start_seen = bus.start && !r_done && (r_state == IDLE);
  assign w_len_bad    = (bus.fnamelen == 8'd0) || (bus.fnamelen > 8'd12);
  assign w_accept     = w_start_seen && !w_len_bad;
  assign w_last       = (r_idx == r_len - 4'd1);
  assign w_xfer       = r_wvalid && bus.wready;

  always_comb begin
    w_char = 8'h00;
    for (int i = 0; i < C_NAME_MAX; i++) begin
      if (r_idx == 4'(i)) w_char = r_name[i];
    end
  end

  assign w_upper    = (w_char >= 8'h61 && w_char <= 8'h7A) ? (w_char - 8'h20) : w_char;
  assign w_is_sep   = r_has_dot && (r_idx == r_dot_idx);
  assign w_in_base  = !r_has_dot || (r_idx < r_dot_idx);
  assign w_ext_pos  = r_idx - r_dot_idx - 4'd1;
  assign w_char_bad = f_illegal(w_char) || ((w_char == C_DOT) && !w_is_sep)
                   || (w_in_base && (r_idx >= 4'd8))
                   || (!w_in_base && !w_is_sep && (w_ext_pos >= 4'd3));
  assign w_fill_bad = r_bad || w_char_bad || (r_has_dot && (r_dot_idx == 4'd0));

  always_comb begin
    w_entry = 8'h00;
    case (r_waddr)
      5'h08:   w_entry = r_ext[0];
      5'h09:   w_entry = r_ext[1];
      5'h0A:   w_entry = r_ext[2];
      5'h0B:   w_entry = C_SPACE;
      5'h1A:   w_entry = r_cluster[7:0];
      5'h1B:   w_entry = r_cluster[15:8];
      5'h1C:   w_entry = r_size[7:0];
      5'h1D:   w_entry = r_size[15:8];
      5'h1E:   w_entry = r_size[23:16];
      5'h1F:   w_entry = r_size[31:24];
      default: w_entry = (r_waddr <= 5'h07) ? r_base[r_waddr[2:0]] : 8'h00;
    endcase
    // 0xE5 marks a deleted entry, so a real leading 0xE5 is stored as 0x05
    if (r_waddr == 5'h00 && w_entry == 8'hE5) w_entry = 8'h05;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_state_nxt = SCAN;
      SCAN:    if (w_last)   w_state_nxt = FILL;
      FILL:    if (w_last)   w_state_nxt = w_fill_bad ? IDLE : EMIT;
      EMIT:    if (w_xfer && r_waddr == C_LAST_ADDR) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < C_NAME_MAX; i++) r_name[i] <= 8'h00;
      for (int i = 0; i < 8; i++) r_base[i] <= 8'h00;
      for (int i = 0; i < 3; i++) r_ext[i] <= 8'h00;
      r_len     <= 4'd0;
      r_idx     <= 4'd0;
      r_dot_idx <= 4'd0;
      r_has_dot <= 1'b0;
      r_bad     <= 1'b0;
      r_cluster <= 16'h0000;
      r_size    <= 32'h0000_0000;
      r_wvalid  <= 1'b0;
      r_waddr   <= 5'd0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_start_seen && w_len_bad) r_err <= 1'b1;
          if (w_accept) begin
            for (int i = 0; i < C_NAME_MAX; i++) r_name[i] <= bus.fname[i];
            for (int i = 0; i < 8; i++) r_base[i] <= C_SPACE;
            for (int i = 0; i < 3; i++) r_ext[i] <= C_SPACE;
            r_len     <= bus.fnamelen[3:0];
            r_cluster <= bus.fcluster;
            r_size    <= bus.fsize;
            r_idx     <= 4'd0;
            r_dot_idx <= 4'd0;
            r_has_dot <= 1'b0;
            r_bad     <= 1'b0;
            r_busy    <= 1'b1;
          end
        end
        SCAN: begin
          if (w_char == C_DOT) begin
            r_has_dot <= 1'b1;
            r_dot_idx <= r_idx;
          end
          r_idx <= w_last ? 4'd0 : r_idx + 4'd1;
        end
        FILL: begin
          if (w_char_bad) r_bad <= 1'b1;
          if (w_in_base && (r_idx < 4'd8))
            r_base[r_idx[2:0]] <= w_upper;
          else if (!w_in_base && !w_is_sep && (w_ext_pos < 4'd3))
            r_ext[w_ext_pos[1:0]] <= w_upper;
          r_idx <= r_idx + 4'd1;
          if (w_last) begin
            r_idx <= 4'd0;
            if (w_fill_bad) begin
              r_err  <= 1'b1;
              r_busy <= 1'b0;
            end else begin
              r_wvalid <= 1'b1;
              r_waddr  <= 5'd0;
            end
          end
        end
        EMIT: begin
          if (w_xfer) begin
            if (r_waddr == C_LAST_ADDR) begin
              r_wvalid <= 1'b0;
              r_busy   <= 1'b0;
              r_done   <= 1'b1;
              r_waddr  <= 5'd0;
            end else begin
              r_waddr <= r_waddr + 5'd1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.wvalid = r_wvalid;
  assign bus.waddr  = r_waddr;
  assign bus.wdata  = r_wvalid ? w_entry : 8'h00;
  assign bus.busy   = r_busy;
  assign bus.done   = r_done;
  assign bus.err    = r_err;

endmodule

`default_nettype wire

// File: tb/tb_dir_entry_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_dir_entry_gen
// Brief    : Directed and randomized 8.3 entries against a behavioural model.
// Revision : 1.0 - initial release
// ============================================================================

module tb_dir_entry_gen;
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  dir_entry_if bus ();
  dir_entry_gen dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int n_checks = 0;
  int n_pass   = 0;

  logic [7:0] nm    [52];
  logic [7:0] exp_e [32];
  logic [7:0] cap   [32];
  int first_valid, err_edge, nxfer, order_err, stall_err, end_err, done_cnt, err_cnt, any_valid;
  int mism_first;

  function automatic logic [7:0] to_upper(input logic [7:0] c);
    return (c >= 8'h61 && c <= 8'h7A) ? c - 8'h20 : c;
  endfunction

  task automatic set_name(input string s);
    for (int i = 0; i < 52; i++) nm[i] = 8'h00;
    for (int i = 0; i < s.len(); i++) nm[i] = s[i];
  endtask

  // Expected entry straight from the 8.3 naming rules
  task automatic model_entry(input int len, input logic [15:0] cl, input logic [31:0] sz,
                             output bit valid);
    int dot;
    int nb;
    int ne;
    logic [7:0] c;
    dot = -1;
    for (int i = 0; i < len; i++) if (nm[i] == 8'h2E) dot = i;
    nb = (dot < 0) ? len : dot;
    ne = (dot < 0) ? 0 : len - dot - 1;
    valid = (nb >= 1) && (nb <= 8) && (ne <= 3);
    for (int i = 0; i < len; i++) begin
      c = nm[i];
      if ((c == 8'h2E && i != dot) ||
          (c inside {[8'h00:8'h20], 8'h22, [8'h2A:8'h2C], 8'h2F, [8'h3A:8'h3F],
                     [8'h5B:8'h5D], 8'h7C, 8'h7F}))
        valid = 1'b0;
    end
    for (int k = 0; k < 32; k++) exp_e[k] = 8'h00;
    for (int k = 0; k < 12; k++) exp_e[k] = 8'h20;
    for (int i = 0; i < nb && i < 8; i++) exp_e[i] = to_upper(nm[i]);
    for (int j = 0; j < ne && j < 3; j++) exp_e[8 + j] = to_upper(nm[dot + 1 + j]);
    if (exp_e[0] == 8'hE5) exp_e[0] = 8'h05;
    exp_e[26] = cl[7:0];
    exp_e[27] = cl[15:8];
    for (int b = 0; b < 4; b++) exp_e[28 + b] = sz[8*b +: 8];
  endtask

  function automatic int count_mism();
    int m;
    m = 0;
    mism_first = -1;
    for (int k = 0; k < 32; k++) begin
      if (cap[k] !== exp_e[k]) begin
        m++;
        if (mism_first < 0) mism_first = k;
      end
    end
    return m;
  endfunction

  task automatic drive_inputs(input int len, input logic [15:0] cl, input logic [31:0] sz);
    bus.fnamelen = 8'(len);
    for (int i = 0; i < 52; i++) bus.fname[i] = nm[i];
    bus.fcluster = cl;
    bus.fsize    = sz;
  endtask

  task automatic apply_start(input int len, input logic [15:0] cl, input logic [31:0] sz);
    drive_inputs(len, cl, sz);
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
  endtask

  // Plays the sink from edge E1 until done or err, recording every transfer
  task automatic run_op(input int duty);
    logic       pv;
    logic [4:0] pa;
    logic [7:0] pd;
    bit         fin;
    first_valid = -1; err_edge = -1; nxfer = 0; order_err = 0; stall_err = 0;
    end_err = 0; done_cnt = 0; err_cnt = 0; any_valid = 0; fin = 0;
    for (int k = 0; k < 32; k++) cap[k] = 8'hxx;
    for (int k = 1; k <= 3000 && !fin; k++) begin
      pv = bus.wvalid; pa = bus.waddr; pd = bus.wdata;
      bus.wready = ($urandom_range(0, 99) < duty);
      @(posedge clk); #1;
      if (bus.wvalid) begin
        any_valid++;
        if (first_valid < 0) first_valid = k;
      end
      if (pv && bus.wready) begin
        if (int'(pa) != nxfer) order_err++;
        cap[pa] = pd;
        nxfer++;
        if (pa == 5'h1F && !(bus.done && !bus.busy && !bus.wvalid)) end_err++;
      end else if (pv) begin
        if (bus.wvalid !== 1'b1 || bus.waddr !== pa || bus.wdata !== pd) stall_err++;
      end
      if (!bus.busy && !bus.done && !bus.err) end_err++;
      if (bus.done) done_cnt++;
      if (bus.err) begin
        err_cnt++;
        err_edge = k;
      end
      if (bus.done || bus.err) fin = 1;
    end
    bus.wready = 1'b0;
    n_checks++;
    if (!fin) $display("FAIL timeout: no done/err within 3000 cycles");
    else n_pass++;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.start = 1'b0; bus.wready = 1'b0;
    set_name("");
    drive_inputs(0, 16'h0, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if ({bus.wvalid, bus.busy, bus.done, bus.err, bus.waddr, bus.wdata} !== 17'd0)
      $display("FAIL reset_outputs: got %h required 0",
               {bus.wvalid, bus.busy, bus.done, bus.err, bus.waddr, bus.wdata});
    else n_pass++;
    rst_n = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if ({bus.wvalid, bus.busy} !== 2'b00)
      $display("FAIL idle_after_reset: wvalid/busy got %b required 00", {bus.wvalid, bus.busy});
    else n_pass++;
  endtask

  task automatic test_readme();
    bit v;
    int m;
    set_name("readme.txt");
    model_entry(10, 16'h1234, 32'h0001_2345, v);
    apply_start(10, 16'h1234, 32'h0001_2345);
    n_checks++;
    if (bus.busy !== 1'b1) $display("FAIL readme_busy: got %b required 1", bus.busy);
    else n_pass++;
    run_op(100);
    n_checks++;
    if (first_valid != 20) $display("FAIL readme_latency: wvalid after edge %0d required 20", first_valid);
    else n_pass++;
    n_checks++;
    if (nxfer != 32 || order_err != 0)
      $display("FAIL readme_count: transfers %0d order errors %0d required 32/0", nxfer, order_err);
    else n_pass++;
    m = count_mism();
    n_checks++;
    if (m != 0) $display("FAIL readme_data: %0d mismatches, first 0x%0h got %h required %h",
                         m, mism_first, cap[mism_first], exp_e[mism_first]);
    else n_pass++;
    n_checks++;
    if ({cap[26], cap[27], cap[28], cap[29], cap[30], cap[31]} !== 48'h3412_4523_0100)
      $display("FAIL readme_tail: got %h required 341245230100",
               {cap[26], cap[27], cap[28], cap[29], cap[30], cap[31]});
    else n_pass++;
    n_checks++;
    if (done_cnt != 1 || end_err != 0)
      $display("FAIL readme_done: done pulses %0d end errors %0d required 1/0", done_cnt, end_err);
    else n_pass++;
    @(posedge clk); #1;
    n_checks++;
    if ({bus.done, bus.busy} !== 2'b00)
      $display("FAIL readme_done_width: done/busy got %b required 00", {bus.done, bus.busy});
    else n_pass++;
  endtask

  task automatic test_single();
    bit v;
    int m;
    set_name("a");
    model_entry(1, 16'h00AB, 32'h0000_0010, v);
    apply_start(1, 16'h00AB, 32'h0000_0010);
    run_op(100);
    n_checks++;
    if (first_valid != 2) $display("FAIL single_latency: wvalid after edge %0d required 2", first_valid);
    else n_pass++;
    m = count_mism();
    n_checks++;
    if (m != 0) $display("FAIL single_data: %0d mismatches, first 0x%0h got %h required %h",
                         m, mism_first, cap[mism_first], exp_e[mism_first]);
    else n_pass++;
    @(posedge clk); #1;
  endtask

  task automatic test_reject();
    string rej [3];
    rej = '{"A.B.C", "A B", ".AB"};
    set_name("ABCDEFGHIJKLM");
    apply_start(13, 16'h1, 32'h1);
    n_checks++;
    if ({bus.err, bus.busy} !== 2'b10)
      $display("FAIL len13_err: err/busy got %b required 10", {bus.err, bus.busy});
    else n_pass++;
    @(posedge clk); #1;
    n_checks++;
    if ({bus.err, bus.busy, bus.wvalid} !== 3'b000)
      $display("FAIL len13_after: err/busy/wvalid got %b required 000", {bus.err, bus.busy, bus.wvalid});
    else n_pass++;
    set_name("ABCDEFGHI.T");
    apply_start(11, 16'h1, 32'h1);
    run_op(100);
    n_checks++;
    if (err_edge != 22 || err_cnt != 1)
      $display("FAIL long_base_err: err after edge %0d (%0d pulses) required 22 (1)", err_edge, err_cnt);
    else n_pass++;
    n_checks++;
    if (any_valid != 0) $display("FAIL long_base_wvalid: wvalid cycles %0d required 0", any_valid);
    else n_pass++;
    @(posedge clk); #1;
    foreach (rej[r]) begin
      set_name(rej[r]);
      apply_start(rej[r].len(), 16'h1, 32'h1);
      run_op(100);
      n_checks++;
      if (err_edge != 2 * rej[r].len())
        $display("FAIL reject_%0d_err: err after edge %0d required %0d", r, err_edge, 2 * rej[r].len());
      else n_pass++;
      n_checks++;
      if (any_valid != 0) $display("FAIL reject_%0d_wvalid: wvalid cycles %0d required 0", r, any_valid);
      else n_pass++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_e5();
    bit v;
    int m;
    set_name("xAB.C");
    nm[0] = 8'hE5;
    model_entry(5, 16'h0002, 32'h0000_0200, v);
    apply_start(5, 16'h0002, 32'h0000_0200);
    run_op(100);
    n_checks++;
    if (cap[0] !== 8'h05) $display("FAIL e5_byte0: got %h required 05", cap[0]);
    else n_pass++;
    n_checks++;
    if ({cap[1], cap[2], cap[8]} !== 24'h414243)
      $display("FAIL e5_fields: got %h required 414243", {cap[1], cap[2], cap[8]});
    else n_pass++;
    m = count_mism();
    n_checks++;
    if (m != 0) $display("FAIL e5_data: %0d mismatches, first 0x%0h got %h required %h",
                         m, mism_first, cap[mism_first], exp_e[mism_first]);
    else n_pass++;
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    bit v;
    int m;
    set_name("readme.txt");
    apply_start(10, 16'h1234, 32'h0001_2345);
    run_op(100);
    set_name("b2b.x");
    model_entry(5, 16'hBEEF, 32'hCAFE_F00D, v);
    drive_inputs(5, 16'hBEEF, 32'hCAFE_F00D);
    bus.start = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if (bus.busy !== 1'b0) $display("FAIL b2b_ignore_on_done: busy got %b required 0", bus.busy);
    else n_pass++;
    @(posedge clk); #1;
    bus.start = 1'b0;
    n_checks++;
    if (bus.busy !== 1'b1) $display("FAIL b2b_accept_after_done: busy got %b required 1", bus.busy);
    else n_pass++;
    run_op(100);
    n_checks++;
    if (first_valid != 10) $display("FAIL b2b_latency: wvalid after edge %0d required 10", first_valid);
    else n_pass++;
    m = count_mism();
    n_checks++;
    if (m != 0 || done_cnt != 1)
      $display("FAIL b2b_data: %0d mismatches, %0d done pulses required 0/1", m, done_cnt);
    else n_pass++;
    @(posedge clk); #1;
  endtask

  task automatic gen_name(output int len);
    string good;
    string bad;
    int nb;
    int ne;
    int dot;
    good = "abcdxyzABCQ0189_-~!#";
    bad  = "*+,/:;<=>?[]| \"\\";
    for (int i = 0; i < 52; i++) nm[i] = 8'h00;
    dot = int'($urandom_range(0, 1));
    nb  = int'($urandom_range((dot == 1) ? 0 : 1, 9));
    ne  = (dot == 1) ? int'($urandom_range(0, 4)) : 0;
    if (nb + dot + ne > 12) ne = 12 - nb - dot;
    len = nb + dot + ne;
    for (int i = 0; i < nb; i++) nm[i] = good[$urandom_range(0, good.len() - 1)];
    if (dot == 1) nm[nb] = 8'h2E;
    for (int j = 0; j < ne; j++) nm[nb + dot + j] = good[$urandom_range(0, good.len() - 1)];
    case ($urandom_range(0, 7))
      0: nm[$urandom_range(0, len - 1)] = bad[$urandom_range(0, bad.len() - 1)];
      1: nm[$urandom_range(0, len - 1)] = 8'h2E;
      2: nm[0] = 8'hE5;
      3: nm[$urandom_range(0, len - 1)] = ($urandom_range(0, 1) == 1) ? 8'h7F : 8'h00;
      default: ;
    endcase
  endtask

  task automatic test_random();
    bit          v;
    int          len;
    int          m;
    logic [15:0] cl;
    logic [31:0] sz;
    for (int it = 0; it < 30; it++) begin
      gen_name(len);
      cl = 16'($urandom);
      sz = $urandom;
      model_entry(len, cl, sz, v);
      apply_start(len, cl, sz);
      run_op(30);
      if (v) begin
        n_checks++;
        if (first_valid != 2 * len || err_cnt != 0)
          $display("FAIL rand%0d_accept: wvalid after edge %0d err %0d required %0d/0",
                   it, first_valid, err_cnt, 2 * len);
        else n_pass++;
        n_checks++;
        if (nxfer != 32 || order_err != 0 || stall_err != 0)
          $display("FAIL rand%0d_stream: transfers %0d order %0d stall %0d required 32/0/0",
                   it, nxfer, order_err, stall_err);
        else n_pass++;
        m = count_mism();
        n_checks++;
        if (m != 0) $display("FAIL rand%0d_data: %0d mismatches, first 0x%0h got %h required %h",
                             it, m, mism_first, cap[mism_first], exp_e[mism_first]);
        else n_pass++;
        n_checks++;
        if (done_cnt != 1 || end_err != 0)
          $display("FAIL rand%0d_done: pulses %0d end errors %0d required 1/0", it, done_cnt, end_err);
        else n_pass++;
      end else begin
        n_checks++;
        if (err_edge != 2 * len || any_valid != 0)
          $display("FAIL rand%0d_reject: err after edge %0d wvalid %0d required %0d/0",
                   it, err_edge, any_valid, 2 * len);
        else n_pass++;
      end
      @(posedge clk); #1;
      n_checks++;
      if ({bus.done, bus.err, bus.busy} !== 3'b000)
        $display("FAIL rand%0d_idle: done/err/busy got %b required 000", it, {bus.done, bus.err, bus.busy});
      else n_pass++;
    end
  endtask

  task automatic test_reset_mid_emit();
    bit v;
    int m;
    int quiet;
    bit hit;
    set_name("readme.txt");
    apply_start(10, 16'h1234, 32'h0001_2345);
    bus.wready = 1'b1;
    hit = 0;
    for (int k = 0; k < 100 && !hit; k++) begin
      @(posedge clk); #1;
      if (bus.wvalid && bus.waddr == 5'd10) hit = 1;
    end
    n_checks++;
    if (!hit) $display("FAIL mid_reset_reach: waddr 10 not reached within 100 cycles");
    else n_pass++;
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({bus.wvalid, bus.busy, bus.waddr, bus.wdata} !== 15'd0)
      $display("FAIL mid_reset_async: got %h required 0", {bus.wvalid, bus.busy, bus.waddr, bus.wdata});
    else n_pass++;
    bus.wready = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    quiet = 0;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      if (bus.wvalid || bus.busy) quiet++;
    end
    n_checks++;
    if (quiet != 0) $display("FAIL mid_reset_quiet: active cycles %0d required 0", quiet);
    else n_pass++;
    set_name("x.c");
    model_entry(3, 16'h0042, 32'h0000_0777, v);
    apply_start(3, 16'h0042, 32'h0000_0777);
    run_op(50);
    n_checks++;
    if (first_valid != 6 || nxfer != 32 || order_err != 0)
      $display("FAIL mid_reset_restart: latency %0d transfers %0d order %0d required 6/32/0",
               first_valid, nxfer, order_err);
    else n_pass++;
    m = count_mism();
    n_checks++;
    if (m != 0) $display("FAIL mid_reset_data: %0d mismatches, first 0x%0h got %h required %h",
                         m, mism_first, cap[mism_first], exp_e[mism_first]);
    else n_pass++;
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_readme();
    test_single();
    test_reject();
    test_e5();
    test_back_to_back();
    test_random();
    test_reset_mid_emit();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/dir_entry_gen.md
DIR_ENTRY_GEN -- requirements
Module: dir_entry_gen

Interface
REQ-001 The module SHALL have one clock and an asynchronous active-low reset: clk input 1 (rising-edge clock); rst_n input 1 (asynchronous reset, active low).
REQ-002 start  input  1: request to build one entry; sampled in IDLE only.
REQ-003 fnamelen  input  8: number of valid bytes in fname.
REQ-004 fname  input  8 x 52 array: file name as ASCII, index 0 first; only indices 0..fnamelen-1 are used.
REQ-005 fcluster  input  16: first cluster of the file.
REQ-006 fsize  input  32: file size in bytes.
REQ-007 wready  input  1: the sink accepts the current byte.
REQ-008 wvalid  output  1: wdata and waddr are valid.
REQ-009 waddr  output  5: byte offset 0x00..0x1F within the 32-byte entry.
REQ-010 wdata  output  8: entry byte at waddr.
REQ-011 busy  output  1: high from start acceptance until done or err.
REQ-012 done  output  1: one-cycle pulse after byte 0x1F is accepted.
REQ-013 err  output  1: one-cycle pulse when the name is rejected; no bytes are emitted.

Function
REQ-014 The state machine SHALL have four states: IDLE, SCAN, FILL and EMIT; start is ignored outside IDLE.
REQ-015 In IDLE, when start=1, the module SHALL check fnamelen: 0 or >12 gives an err pulse on the next cycle, the FSM stays in IDLE and busy stays 0.
REQ-016 Otherwise, on the start edge (E0), all inputs SHALL be latched, busy set to 1 and the FSM moved to SCAN.
REQ-017 SCAN SHALL inspect one character per cycle on edges E1..EL (L=fnamelen) and record the index of the last '.'.
REQ-018 FILL SHALL process one character per cycle on edges E(L+1)..E(2L).
REQ-019 In FILL, characters before the last dot SHALL go to the base field; characters after it SHALL go to the extension field; with no dot, all characters go to the base field.
REQ-020 FILL SHALL convert a-z to upper case, and the base (8 bytes) and extension (3 bytes) fields SHALL be space-padded (0x20).
REQ-021 Rejection SHALL be flagged at edge E2L and SHALL produce an err pulse, busy=0 and a return to IDLE, for any of: base length >8; extension length >3; base length 0 (leading dot); any byte <0x21 or equal to 0x22, 0x2A-0x2C, 0x2F, 0x3A-0x3F, 0x5B-0x5D, 0x7C or 0x7F; any '.' other than the last one.
REQ-022 A trailing dot SHALL be accepted and gives an empty extension.
REQ-023 If valid, at edge E2L the FSM SHALL enter EMIT with wvalid=1, waddr=0.
REQ-024 The entry layout SHALL be: 0x00-0x07 base; 0x08-0x0A extension; 0x0B = 0x20 (archive attribute); 0x0C-0x19 = 0x00.
REQ-025 The entry layout SHALL continue: 0x1A-0x1B = fcluster little-endian; 0x1C-0x1F = fsize little-endian.
REQ-026 If base byte 0 equals 0xE5, the module SHALL emit 0x05 at offset 0x00.
REQ-027 Handshake: a byte transfers on a rising edge with wvalid&&wready; while wready=0, wvalid, waddr and wdata SHALL hold stable.
REQ-028 After a transfer, waddr SHALL increment by 1 on the same edge; bytes SHALL be emitted in strictly ascending order with no gaps or repeats.
REQ-029 On transfer of offset 0x1F: wvalid=0, busy=0 and done=1 for exactly one cycle, then the FSM returns to IDLE.
REQ-030 A start asserted in the same cycle as done SHALL be ignored.
REQ-031 Back-to-back operation: a start in the cycle after done SHALL be accepted.

Reset
REQ-032 When rst_n=0, all of the following SHALL be forced immediately, asynchronously and at any state including mid-SCAN, FILL or EMIT: state IDLE; wvalid=0; waddr=0; wdata=0; busy=0; done=0; err=0; all latched fields and counters 0.
REQ-033 After rst_n deasserts, the module SHALL emit no partial entry; a new start SHALL produce a full entry from offset 0x00.

Verification
REQ-034 "readme.txt" (L=10), fcluster=0x1234, fsize=0x00012345, wready=1 -> wvalid rises after edge 20; bytes "README  TXT", 0x20, 14 x 0x00, 34 12 45 23 01 00; done pulses once; busy falls with it.
REQ-035 "a" (L=1) -> bytes 0x00-0x0A = "A" followed by 10 spaces; first wvalid after edge 2.
REQ-036 fnamelen=13 -> err on the next cycle with busy=0. "ABCDEFGHI.T" -> err after edge 22. "A.B.C" and "A B" -> err. In all cases wvalid never asserts.
REQ-037 Random wready duty (about 30%) -> exactly 32 transfers, offsets 0..31 in order, and wdata constant while stalled.
REQ-038 fname[0]=0xE5, "\xE5AB.C" -> offset 0x00 = 0x05, 0x01-0x02 = "AB", 0x08 = "C".
REQ-039 rst_n pulsed low while waddr=10 in EMIT -> wvalid=0 and busy=0 in the same cycle; a following start yields a complete, correct entry starting at 0x00.
